vga_scanout: RTL and testbench
==============================

# vga_scanout

Parametrised VGA scan-out engine: generates horizontal/vertical timing, reads pixels from port B of the dual-port frame RAM, and drives the 3-bit-per-channel VGA pins. It is the generalised successor to the fixed-size debug VGA block in the `CPU` top level. It adds configurable timing, integer pixel replication, explicit RAM read-latency compensation, sync polarity, and frame/line status pulses. It runs entirely in the VGA clock domain.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SCALE_SHIFT, 2, each framebuffer pixel is replicated 2^SCALE_SHIFT times horizontally and vertically
- ADDR_W, 15, frame RAM address width
- COLOR_W, 3, bits per colour channel
- RAM_LATENCY, 2, clocks from `address` change to valid `q` (1..4)
- SYNC_POL, 0, active level of HS/VS (0 = active-low)
- clock  in  1  pixel clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  scan enable; low holds timing at origin with outputs blanked
- address  out  ADDR_W  frame RAM read address
- q  in  3*COLOR_W  RAM read data, {R,G,B}, R in the MSBs
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  colour outputs
- HS / VS  out  1  sync outputs
- frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame on the pins
- line_start  out  1  one-clock pulse aligned with the first active pixel of each visible line on the pins

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- h counter runs 0..H_TOTAL-1. v increments when h wraps, and runs 0..V_TOTAL-1. Active region: h<H_ACTIVE and v<V_ACTIVE.
- HS is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS uses the same rule on v.
- FB_W = H_ACTIVE>>SCALE_SHIFT (160). FB_H = V_ACTIVE>>SCALE_SHIFT (120).
- Address generation is incremental; no multiplier.
  - `address` increments once per 2^SCALE_SHIFT active clocks.
  - At the end of each active line, `address` reloads from a line_base register.
  - line_base advances by FB_W after every 2^SCALE_SHIFT-th visible line.
  - line_base and address return to 0 at the start of each frame.
- Outside the active region, RGB is forced to 0 regardless of `q`.
- `enable` low behaviour:
  - h, v, address and line_base are held at 0.
  - RGB are 0; HS and VS are at their inactive level (~SYNC_POL); pulses are 0.
  - When `enable` rises, the frame restarts from origin.
- Reset state: h=v=0, address=0, line_base=0, RGB=0, HS=VS=~SYNC_POL, frame_start=line_start=0. All pipeline stages are cleared.
- Reset asserted mid-frame takes effect on the next edge. Scan restarts from origin on the first edge after reset deasserts.
- Elaboration errors:
  - H_ACTIVE or V_ACTIVE not divisible by 2^SCALE_SHIFT.
  - FB_W*FB_H > 2^ADDR_W.

## Timing
- Pipeline depth D = RAM_LATENCY+2 clocks from counter state to pins:
  - 1 stage registers `address`.
  - RAM_LATENCY stages are spent in the RAM.
  - 1 stage is the output register.
- The active flag, HS, VS, frame_start and line_start go through a D-stage delay line. All pin outputs are therefore mutually aligned.
- With defaults, the first active pixel (h=v=0) of the frame reaches the pins 4 clocks after the first edge where reset=0 and enable=1.
- HS period is exactly H_TOTAL clocks. VS period is exactly H_TOTAL*V_TOTAL clocks.
- `address` is stable for 2^SCALE_SHIFT consecutive clocks within a replicated pixel.

## Structure
- Package `vga_pkg` holds:
  - the default 640x480@60 timing constants;
  - `rgb_t`, a packed struct {r,g,b} of COLOR_W bits each;
  - a `clog2`-based counter width helper.
- One sub-module, `vga_timing`, contains the h/v counters, sync decode, active flag and start flags. `vga_scanout` adds the address generator, the delay line and the output register.

## Test plan
- Reset and enable: hold reset 5 clocks with enable=1, then release -> during reset RGB=0, HS=VS=1, address=0; first nonzero `q` appears on RGB at clock 4 after release, with frame_start=1 at that same clock.
- Sync timing: run 2 frames with defaults -> HS low for 96 clocks every 800; VS low for 1600 clocks every 420000; HS/VS never active during active RGB.
- Address and replication: RAM model returns q=address -> line 0 addresses are 0,0,0,0,1,1,1,1,… up to 159. Lines 0–3 share base 0; line 4 starts at 160; last visible address is 19199; the next frame starts at 0.
- Blanking: drive q=9'h1FF constantly -> RGB=0 for every clock outside the 640x480 window.
- Latency sweep: RAM_LATENCY=1 and 4 with matching RAM models -> the pixel at h=0, v=0 appears at 3 and 6 clocks after start respectively; sync stays aligned.
- Mid-frame disruption: drop enable at v=200, h=300 for 10 clocks, then reassert; separately, pulse reset at the same point -> outputs blank next clock and the next frame_start occurs D clocks after resume.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA scan-out engine.
// Holds the default 640x480@60 timing, the {r,g,b} pixel struct, the
// per-pixel control word that travels down the delay line, and a
// counter width helper.
package vga_pkg;

    // Default 640x480@60 timing, frame RAM geometry and pin format
    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_H_FP        = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BP        = 48;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_V_FP        = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BP        = 33;
    localparam int unsigned DEF_SCALE_SHIFT = 2;
    localparam int unsigned DEF_ADDR_W      = 15;
    localparam int unsigned DEF_COLOR_W     = 3;
    localparam int unsigned DEF_RAM_LATENCY = 2;
    localparam int unsigned DEF_SYNC_POL    = 0;

    // One pixel as stored in the frame RAM, R in the MSBs
    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    // Per-clock control flags; sync bits are "asserted", polarity applied at the pins
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic frame_start;
        logic line_start;
    } ctrl_t;

    // Bits needed to hold values 0..n-1
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: frame RAM read port plus VGA pin bundle.
//   address     : scan-out -> RAM read address
//   q           : RAM -> scan-out read data {R,G,B}
//   VGA_R/G/B   : colour pins
//   HS / VS     : sync pins
//   frame_start : pulse with the first active pixel of a frame
//   line_start  : pulse with the first active pixel of each visible line
interface vga_scanout_if
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned COLOR_W = DEF_COLOR_W
);
    logic [ADDR_W-1:0]    address;
    logic [3*COLOR_W-1:0] q;
    logic [COLOR_W-1:0]   VGA_R;
    logic [COLOR_W-1:0]   VGA_G;
    logic [COLOR_W-1:0]   VGA_B;
    logic                 HS;
    logic                 VS;
    logic                 frame_start;
    logic                 line_start;

    modport master (
        output address, VGA_R, VGA_G, VGA_B, HS, VS, frame_start, line_start,
        input  q
    );

    modport slave (
        input  address, VGA_R, VGA_G, VGA_B, HS, VS, frame_start, line_start,
        output q
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters and per-position decode.
//   clock_i, reset_i, enable_i : pixel clock, sync active-high reset, scan enable
//   run_o   : counters hold a valid scan position this cycle
//   h_o/v_o : current scan position
//   ctrl_o  : decode of the previous cycle's position (active, sync, start flags),
//             aligned with the address register in the parent
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned HW       = cnt_w(DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP + 1),
    parameter int unsigned VW       = cnt_w(DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP + 1)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          enable_i,
    output logic          run_o,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output ctrl_t         ctrl_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic          run_q;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    ctrl_t         ctrl_q, ctrl_d;

    // Counters advance only once the origin has been held for one clock,
    // so position (0,0) always occupies the cycle after the first run edge.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (run_q) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Position decode
    always_comb begin
        ctrl_d = '0;
        if (run_q) begin
            ctrl_d.active      = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
            ctrl_d.hs          = (h_q >= HW'(H_ACTIVE + H_FP)) &&
                                 (h_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
            ctrl_d.vs          = (v_q >= VW'(V_ACTIVE + V_FP)) &&
                                 (v_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
            ctrl_d.frame_start = (h_q == '0) && (v_q == '0);
            ctrl_d.line_start  = (h_q == '0) && (v_q < VW'(V_ACTIVE));
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || !enable_i) begin
            run_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            ctrl_q <= '0;
        end else begin
            run_q  <= 1'b1;
            h_q    <= h_d;
            v_q    <= v_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign run_o  = run_q;
    assign h_o    = h_q;
    assign v_o    = v_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA scan-out engine with pixel replication and RAM latency compensation.
//   clock  : pixel clock (rising edge)
//   reset  : synchronous, active-high
//   enable : scan enable; low holds the origin with the pins blanked
//   bus    : master side of vga_scanout_if (RAM address/q, colour, sync, start pulses)
// Pipeline from scan position to pins is RAM_LATENCY+2 clocks: address register,
// RAM, output register; control flags ride a matching delay line.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned COLOR_W     = DEF_COLOR_W,
    parameter int unsigned RAM_LATENCY = DEF_RAM_LATENCY,
    parameter int unsigned SYNC_POL    = DEF_SYNC_POL
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    vga_scanout_if.master bus
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = cnt_w(H_TOTAL + 1);
    localparam int unsigned VW       = cnt_w(V_TOTAL + 1);
    localparam int unsigned REP      = 32'd1 << SCALE_SHIFT;
    localparam int unsigned FB_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_H     = V_ACTIVE >> SCALE_SHIFT;
    localparam logic        SYNC_ACT = 1'(SYNC_POL);

    // Elaboration-time parameter checks
    if (((H_ACTIVE % REP) != 0) || ((V_ACTIVE % REP) != 0)) begin : g_bad_scale
        $error("vga_scanout: active size not divisible by 2**SCALE_SHIFT");
    end
    if ((64'(FB_W) * 64'(FB_H)) > (64'd1 << ADDR_W)) begin : g_bad_addr
        $error("vga_scanout: framebuffer does not fit in ADDR_W");
    end
    if ((RAM_LATENCY < 1) || (RAM_LATENCY > 4)) begin : g_bad_lat
        $error("vga_scanout: RAM_LATENCY must be 1..4");
    end

    logic          scan_run;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    ctrl_t         ctrl_s1;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clock_i  (clock),
        .reset_i  (reset),
        .enable_i (enable),
        .run_o    (scan_run),
        .h_o      (h_cnt),
        .v_o      (v_cnt),
        .ctrl_o   (ctrl_s1)
    );

    logic              h_vis, v_vis;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;

    assign h_vis = h_cnt < HW'(H_ACTIVE);
    assign v_vis = v_cnt < VW'(V_ACTIVE);

    // Incremental address: step once per replicated pixel, park on the next
    // line's base during blanking, advance the base after each REP-th line.
    always_comb begin
        address_d   = address_q;
        line_base_d = line_base_q;
        if (!scan_run) begin
            address_d   = '0;
            line_base_d = '0;
        end else if (h_vis && v_vis) begin
            if ((h_cnt != '0) && ((h_cnt & HW'(REP - 1)) == '0)) begin
                address_d = address_q + 1'b1;
            end
            if (h_cnt == HW'(H_ACTIVE - 1)) begin
                if (v_cnt == VW'(V_ACTIVE - 1)) begin
                    line_base_d = '0;
                end else if ((v_cnt & VW'(REP - 1)) == VW'(REP - 1)) begin
                    line_base_d = line_base_q + ADDR_W'(FB_W);
                end
            end
        end else begin
            address_d = line_base_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            address_q   <= '0;
            line_base_q <= '0;
        end else begin
            address_q   <= address_d;
            line_base_q <= line_base_d;
        end
    end

    // Control delay line covering the RAM read latency
    ctrl_t dly_q [RAM_LATENCY];
    ctrl_t tail;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= ctrl_s1;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign tail = dly_q[RAM_LATENCY-1];

    // Output register: blank outside the active window, apply sync polarity
    logic [3*COLOR_W-1:0] rgb_q;
    logic                 hs_q, vs_q, fs_q, ls_q;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            rgb_q <= '0;
            hs_q  <= ~SYNC_ACT;
            vs_q  <= ~SYNC_ACT;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            rgb_q <= tail.active ? bus.q : '0;
            hs_q  <= tail.hs ? SYNC_ACT : ~SYNC_ACT;
            vs_q  <= tail.vs ? SYNC_ACT : ~SYNC_ACT;
            fs_q  <= tail.frame_start;
            ls_q  <= tail.line_start;
        end
    end

    assign bus.address     = address_q;
    assign bus.VGA_R       = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign bus.VGA_G       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.VGA_B       = rgb_q[COLOR_W-1:0];
    assign bus.HS          = hs_q;
    assign bus.VS          = vs_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: three scan-out instances on a reduced 16x8 timing
// (scale/latency/polarity variants) sharing clock, reset, enable and one
// framebuffer image; a position-based model predicts every pin every clock.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int HA  = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA  = 8,  VFP = 1, VSY = 2, VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int AW  = 7;
    localparam int NI  = 3;

    function automatic int ss_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int pol_of(input int g);
        return (g == 1) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    logic [8:0]    mem [1 << AW];
    logic [AW-1:0] addr_w [NI];
    logic [8:0]    rgb_w  [NI];
    logic          hs_w   [NI];
    logic          vs_w   [NI];
    logic          fs_w   [NI];
    logic          ls_w   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned S = ss_of(g);
        localparam int unsigned L = lat_of(g);
        localparam int unsigned P = pol_of(g);

        vga_scanout_if #(.ADDR_W(AW), .COLOR_W(3)) vif ();

        vga_scanout #(
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
            .SCALE_SHIFT(S), .ADDR_W(AW), .COLOR_W(3),
            .RAM_LATENCY(L), .SYNC_POL(P)
        ) dut (
            .clock  (clk),
            .reset  (rst),
            .enable (en),
            .bus    (vif)
        );

        // RAM read port with L clocks from address to q
        logic [8:0] rp [4];
        always_ff @(posedge clk) begin
            rp[0] <= mem[vif.address];
            for (int j = 1; j < 4; j++) rp[j] <= rp[j-1];
        end
        assign vif.q = rp[L-1];

        assign addr_w[g] = vif.address;
        assign rgb_w[g]  = {vif.VGA_R, vif.VGA_G, vif.VGA_B};
        assign hs_w[g]   = vif.HS;
        assign vs_w[g]   = vif.VS;
        assign fs_w[g]   = vif.frame_start;
        assign ls_w[g]   = vif.line_start;
    end

    int total = 0;
    int bad   = 0;
    int c     = 0;   // consecutive edges with reset=0 and enable=1

    always @(posedge clk) c <= (!rst && en) ? c + 1 : 0;

    task automatic chk(input string nm, input int i, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s inst=%0d run_clk=%0d got=%0h exp=%0h", nm, i, c, got, exp);
        end
    endtask

    // Pins after the c-th run edge show scan position p = c-1-D
    task automatic check_inst(input int i);
        int   d, s, pol, fbw, p, m, h, v, eh, ev, efs, els;
        rgb_t got, er;
        d   = lat_of(i) + 2;
        s   = ss_of(i);
        pol = pol_of(i);
        fbw = HA >> s;
        er  = '0;
        eh  = 1 - pol;
        ev  = 1 - pol;
        efs = 0;
        els = 0;
        p   = c - 1 - d;
        if (p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            if (h < HA && v < VA) er = mem[AW'((v >> s) * fbw + (h >> s))];
            if (h >= HA + HFP && h < HA + HFP + HSY) eh = pol;
            if (v >= VA + VFP && v < VA + VFP + VSY) ev = pol;
            efs = (h == 0 && v == 0) ? 1 : 0;
            els = (h == 0 && v < VA) ? 1 : 0;
        end
        got = rgb_w[i];
        chk("rgb", i, int'(got), int'(er));
        chk("hs", i, int'(hs_w[i]), eh);
        chk("vs", i, int'(vs_w[i]), ev);
        chk("frame_start", i, int'(fs_w[i]), efs);
        chk("line_start", i, int'(ls_w[i]), els);
        // address register holds the position of the previous cycle
        m = c - 2;
        if (c <= 1) begin
            chk("addr_idle", i, int'(addr_w[i]), 0);
        end else begin
            h = m % HT;
            v = (m / HT) % VT;
            if (h < HA && v < VA) chk("addr", i, int'(addr_w[i]), (v >> s) * fbw + (h >> s));
        end
    endtask

    // Hand-computed pins at fixed points after a scan start
    task automatic check_literals();
        if (c == 0 && rst) begin
            chk("rst_rgb", 0, int'(rgb_w[0]), 0);
            chk("rst_hs", 0, int'(hs_w[0]), 1);
            chk("rst_vs", 0, int'(vs_w[0]), 1);
            chk("rst_addr", 0, int'(addr_w[0]), 0);
            chk("rst_hs_pol1", 1, int'(hs_w[1]), 0);
        end
        if (c == 3) chk("lit_addr_s0", 2, int'(addr_w[2]), 1);
        if (c == 4) chk("lit_first_l1", 2, int'(rgb_w[2]), 9'h155);
        if (c == 5) begin
            chk("lit_first_l2", 0, int'(rgb_w[0]), 9'h155);
            chk("lit_fs_l2", 0, int'(fs_w[0]), 1);
        end
        if (c == 6) chk("lit_rep_l2", 0, int'(rgb_w[0]), 9'h155);
        if (c == 7) begin
            chk("lit_px1_l2", 0, int'(rgb_w[0]), 9'h0AA);
            chk("lit_first_l4", 1, int'(rgb_w[1]), 9'h155);
            chk("lit_fs_l4", 1, int'(fs_w[1]), 1);
        end
        if (c == 22)  chk("lit_hs_pre", 0, int'(hs_w[0]), 1);
        if (c == 23)  chk("lit_hs_on", 0, int'(hs_w[0]), 0);
        if (c == 26)  chk("lit_hs_off", 0, int'(hs_w[0]), 1);
        if (c == 98)  chk("lit_addr_line4", 0, int'(addr_w[0]), 16);
        if (c == 185) chk("lit_addr_last", 0, int'(addr_w[0]), 31);
        if (c == 220) chk("lit_vs_pre", 0, int'(vs_w[0]), 1);
        if (c == 221) chk("lit_vs_on", 0, int'(vs_w[0]), 0);
        if (c == 293) chk("lit_fs_frame2", 0, int'(fs_w[0]), 1);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) check_inst(i);
        check_literals();
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = 9'($urandom);
        mem[0] = 9'h155;
        mem[1] = 9'h0AA;
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (700) @(posedge clk);
        // random disruptions: enable drops and reset pulses mid-scan
        for (int k = 0; k < 25; k++) begin
            #1;
            if ($urandom_range(0, 1) == 1) begin
                en = 1'b0;
                repeat ($urandom_range(1, 12)) @(posedge clk);
                #1 en = 1'b1;
            end else begin
                rst = 1'b1;
                en  = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 rst = 1'b0;
                en  = 1'b1;
            end
            repeat ($urandom_range(40, 600)) @(posedge clk);
        end
        repeat (700) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
